branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter DEPTH, 4, number of outstanding predicted branches (power of 2, >=2).
REQ-002 Parameter ADDR_W, 8, branch address width.
REQ-003 Parameter GHR_W, 8, global history snapshot width.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 push  in  1  fetch issued a predicted branch this cycle.
REQ-008 push_addr  in  ADDR_W  branch instruction address.
REQ-009 push_opcode  in  7  branch opcode: 1100011 conditional, 1101111 JAL, 1100111 JALR.
REQ-010 push_pred  in  1  predicted direction from the gshare predictor, 1=taken.
REQ-011 push_ghr  in  GHR_W  history register value used for that prediction.
REQ-012 resolve_valid  in  1  execute resolved the oldest outstanding branch.
REQ-013 resolve_taken  in  1  actual direction of that branch.
REQ-014 update  out  1  one-cycle pulse that trains the predictor.
REQ-015 update_address  out  ADDR_W  address to train.
REQ-016 branch_taken  out  1  actual outcome for training.
REQ-017 mispredict  out  1  one-cycle flush pulse to the front end.
REQ-018 restore_ghr  out  GHR_W  corrected history, valid while mispredict=1.
REQ-019 full, empty  out  1 each  queue status, combinational from count.
REQ-020 count  out  clog2(DEPTH)+1  number of occupied entries.
REQ-021 err_overflow, err_underflow  out  1 each  sticky error flags.

Function
REQ-022 The queue SHALL be an in-order circular FIFO. Each entry holds {addr, opcode, pred, ghr}. Pointers wrap modulo DEPTH.
REQ-023 An accepted push SHALL write at the tail. A push is accepted when not full, or when full with a same-cycle non-flushing resolve.
REQ-024 A rejected push SHALL leave the state unchanged and SHALL set err_overflow.
REQ-025 A resolve_valid while empty SHALL be ignored and SHALL set err_underflow; no output pulses.
REQ-026 A valid resolve SHALL pop the head entry. Effective outcome: resolve_taken for a conditional opcode; forced 1 for JAL/JALR.
REQ-027 Latency: outputs SHALL be registered and SHALL appear exactly 1 cycle after the resolve edge.
REQ-028 The update pulse SHALL fire only for a conditional opcode, with update_address=head addr and branch_taken=effective outcome. JAL/JALR SHALL NOT pulse update.
REQ-029 mispredict SHALL pulse when effective outcome != head pred, for any opcode.
REQ-030 On mispredict, restore_ghr SHALL be {head ghr[GHR_W-2:0], effective outcome}; otherwise it holds its last value.
REQ-031 Mispredict flush: in the resolving cycle, all younger entries SHALL be discarded (count->0, head=tail), and any same-cycle push SHALL be dropped without setting err_overflow.
REQ-032 A push and a correct resolve in the same cycle SHALL leave count unchanged.
REQ-033 Any other push or correct resolve SHALL change count by +1 or -1; count SHALL never exceed DEPTH.
REQ-034 update and mispredict SHALL never be high for more than one consecutive cycle per resolve.
REQ-035 Error flags SHALL clear only on reset.

Reset
REQ-036 While rst=0, the block SHALL set pointers=0, count=0, empty=1, full=0, update=0, mispredict=0, branch_taken=0, update_address=0, restore_ghr=0, and err_*=0.
REQ-037 Reset asserted mid-operation SHALL discard all entries immediately and suppress any pending output pulse.
REQ-038 Entry storage need not be reset.

Verification
REQ-039 Push conditional addr=4, pred=1, ghr=0x00; resolve taken=1 -> next cycle update=1, update_address=4, branch_taken=1, mispredict=0, empty=1.
REQ-040 Push conditional addr=8, pred=1, ghr=0x5A; resolve taken=0 -> update=1, branch_taken=0, mispredict=1, restore_ghr=0xB4.
REQ-041 Push JAL addr=0x10, pred=0; resolve -> update=0, mispredict=1, restore_ghr LSB=1; push JALR pred=1; resolve -> no pulses.
REQ-042 Push 4 entries -> full=1; 5th push alone -> rejected, err_overflow=1; then push and correct resolve together -> count stays 4, FIFO order preserved.
REQ-043 Push 3 entries; oldest mispredicts while a push is presented -> count=0 next cycle, push dropped, err_overflow=0.
REQ-044 resolve_valid on empty -> err_underflow=1, no pulses. Assert rst=0 with 2 entries and while a resolve is in progress -> count=0 asynchronously, no update pulse.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue of predicted branches, resolves oldest and trains/flushes
// Holds {addr, opcode, pred, ghr} per outstanding branch; a resolve pops the head and emits registered
// training/flush pulses one cycle later. A mispredict discards every younger entry in the same cycle.
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int GHR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [6:0]               push_opcode,
  input  logic                     push_pred,
  input  logic [GHR_W-1:0]         push_ghr,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     update,
  output logic [ADDR_W-1:0]        update_address,
  output logic                     branch_taken,
  output logic                     mispredict,
  output logic [GHR_W-1:0]         restore_ghr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_COND = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [6:0]        mem_op   [DEPTH];
  logic              mem_pred [DEPTH];
  logic [GHR_W-1:0]  mem_ghr  [DEPTH];

  logic [PTR_W-1:0] head, tail;

  logic [ADDR_W-1:0] head_addr;
  logic [6:0]        head_op;
  logic              head_pred;
  logic [GHR_W-1:0]  head_ghr;

  logic              head_is_cond;
  logic              resolve_ok;
  logic              eff_taken;
  logic              flush;
  logic              push_ok;
  logic              push_rej;
  logic              underflow;
  logic [GHR_W-1:0]  restore_next;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  assign head_addr = mem_addr[head];
  assign head_op   = mem_op[head];
  assign head_pred = mem_pred[head];
  assign head_ghr  = mem_ghr[head];

  // JAL/JALR are always taken; only conditional branches use the execute outcome.
  always_comb begin
    head_is_cond = (head_op == OP_COND);
    resolve_ok   = resolve_valid && !empty;
    eff_taken    = head_is_cond ? resolve_taken : 1'b1;
    flush        = resolve_ok && (eff_taken != head_pred);
    push_ok      = push && !flush && (!full || resolve_ok);
    push_rej     = push && !flush && full && !resolve_ok;
    underflow    = resolve_valid && empty;
    restore_next = (head_ghr << 1) | {{(GHR_W-1){1'b0}}, eff_taken};
  end

  // Entry payload carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem_addr[tail] <= push_addr;
      mem_op[tail]   <= push_opcode;
      mem_pred[tail] <= push_pred;
      mem_ghr[tail]  <= push_ghr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_ok)    tail <= tail + 1'b1;
      if (resolve_ok) head <= head + 1'b1;
      case ({push_ok, resolve_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update         <= 1'b0;
      update_address <= '0;
      branch_taken   <= 1'b0;
      mispredict     <= 1'b0;
      restore_ghr    <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      update     <= resolve_ok && head_is_cond;
      mispredict <= flush;
      if (resolve_ok && head_is_cond) begin
        update_address <= head_addr;
        branch_taken   <= eff_taken;
      end
      if (flush) restore_ghr <= restore_next;
      err_overflow  <= err_overflow  | push_rej;
      err_underflow <= err_underflow | underflow;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

  localparam logic [6:0] OP_COND = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_addr = '0;
  logic [6:0] push_opcode = '0;
  logic       push_pred = 1'b0;
  logic [7:0] push_ghr = '0;
  logic       resolve_valid = 1'b0;
  logic       resolve_taken = 1'b0;
  logic       update, branch_taken, mispredict, full, empty, err_overflow, err_underflow;
  logic [7:0] update_address, restore_ghr;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(.DEPTH(4), .ADDR_W(8), .GHR_W(8)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_addr(push_addr), .push_opcode(push_opcode),
    .push_pred(push_pred), .push_ghr(push_ghr),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .update(update), .update_address(update_address), .branch_taken(branch_taken),
    .mispredict(mispredict), .restore_ghr(restore_ghr),
    .full(full), .empty(empty), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present inputs for one cycle; on return we sit 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [7:0] a, input logic [6:0] op,
                     input logic pr, input logic [7:0] g, input logic rv, input logic rt);
    push = p; push_addr = a; push_opcode = op; push_pred = pr; push_ghr = g;
    resolve_valid = rv; resolve_taken = rt;
    @(posedge clk); #1;
    push = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
  endtask

  task automatic psh(input logic [7:0] a, input logic [6:0] op, input logic pr, input logic [7:0] g);
    cyc(1'b1, a, op, pr, g, 1'b0, 1'b0);
  endtask

  task automatic res(input logic rt);
    cyc(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 1'b1, rt);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_update", update, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_branch_taken", branch_taken, 0);
    check("rst_update_address", update_address, 0);
    check("rst_restore_ghr", restore_ghr, 0);
    check("rst_err_ovf", err_overflow, 0);
    check("rst_err_unf", err_underflow, 0);
    rst = 1'b1;
    idle();

    // Correctly predicted taken conditional
    psh(8'h04, OP_COND, 1'b1, 8'h00);
    check("c1_count", count, 1);
    res(1'b1);
    check("c1_update", update, 1);
    check("c1_addr", update_address, 8'h04);
    check("c1_taken", branch_taken, 1);
    check("c1_mis", mispredict, 0);
    check("c1_empty", empty, 1);
    idle();
    check("c1_update_drop", update, 0);

    // Conditional mispredict: restore = {0x5A[6:0], 0} = 0xB4
    psh(8'h08, OP_COND, 1'b1, 8'h5A);
    res(1'b0);
    check("c2_update", update, 1);
    check("c2_taken", branch_taken, 0);
    check("c2_mis", mispredict, 1);
    check("c2_restore", restore_ghr, 8'hB4);
    idle();
    check("c2_mis_drop", mispredict, 0);
    check("c2_restore_hold", restore_ghr, 8'hB4);

    // JAL predicted not-taken mispredicts; restore = {0x03[6:0],1} = 0x07
    psh(8'h10, OP_JAL, 1'b0, 8'h03);
    res(1'b0);
    check("jal_update", update, 0);
    check("jal_mis", mispredict, 1);
    check("jal_restore_lsb", restore_ghr[0], 1);
    check("jal_restore", restore_ghr, 8'h07);
    psh(8'h14, OP_JALR, 1'b1, 8'h44);
    res(1'b0);
    check("jalr_update", update, 0);
    check("jalr_mis", mispredict, 0);
    check("jalr_restore_hold", restore_ghr, 8'h07);
    check("jalr_empty", empty, 1);

    // Mispredict flushes younger entries and drops a same-cycle push
    psh(8'h40, OP_COND, 1'b1, 8'h11);
    psh(8'h44, OP_COND, 1'b1, 8'h22);
    psh(8'h48, OP_COND, 1'b1, 8'h33);
    check("fl_count3", count, 3);
    cyc(1'b1, 8'h4C, OP_COND, 1'b1, 8'h44, 1'b1, 1'b0);
    check("fl_mis", mispredict, 1);
    check("fl_restore", restore_ghr, 8'h22);
    check("fl_addr", update_address, 8'h40);
    check("fl_count0", count, 0);
    check("fl_empty", empty, 1);
    check("fl_err_ovf", err_overflow, 0);
    psh(8'h50, OP_COND, 1'b0, 8'h00);
    check("fl_count_after", count, 1);
    res(1'b0);
    check("fl_next_addr", update_address, 8'h50);
    check("fl_next_mis", mispredict, 0);

    // Fill, overflow, and simultaneous push + correct resolve while full
    psh(8'h20, OP_COND, 1'b1, 8'h01);
    psh(8'h24, OP_COND, 1'b1, 8'h02);
    psh(8'h28, OP_COND, 1'b1, 8'h03);
    psh(8'h2C, OP_COND, 1'b1, 8'h04);
    check("ov_full", full, 1);
    check("ov_count4", count, 4);
    psh(8'h30, OP_COND, 1'b1, 8'h05);
    check("ov_err", err_overflow, 1);
    check("ov_count_hold", count, 4);
    cyc(1'b1, 8'h34, OP_COND, 1'b1, 8'h06, 1'b1, 1'b1);
    check("ov_pr_count", count, 4);
    check("ov_pr_addr", update_address, 8'h20);
    check("ov_pr_mis", mispredict, 0);
    res(1'b1);
    check("ov_order1", update_address, 8'h24);
    res(1'b1);
    check("ov_order2", update_address, 8'h28);
    res(1'b1);
    check("ov_order3", update_address, 8'h2C);
    res(1'b1);
    check("ov_order4", update_address, 8'h34);
    check("ov_empty", empty, 1);
    check("ov_err_sticky", err_overflow, 1);

    // Resolve while empty
    res(1'b1);
    check("unf_err", err_underflow, 1);
    check("unf_update", update, 0);
    check("unf_mis", mispredict, 0);
    check("unf_count", count, 0);

    // Asynchronous reset during a pending resolve
    psh(8'h60, OP_COND, 1'b1, 8'h00);
    psh(8'h64, OP_COND, 1'b1, 8'h00);
    check("ar_count2", count, 2);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("ar_count_async", count, 0);
    check("ar_empty_async", empty, 1);
    check("ar_err_ovf_clr", err_overflow, 0);
    check("ar_err_unf_clr", err_underflow, 0);
    @(posedge clk); #1;
    check("ar_update", update, 0);
    check("ar_mis", mispredict, 0);
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    rst = 1'b1;
    idle();
    check("ar_update_after", update, 0);
    check("ar_count_after", count, 0);
    pulse_reset();
    check("ar_final_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
